// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Moore control sequencer for a shared-memory multicycle RV32
//            datapath (fetch / decode / execute / memory / writeback).
//            Handles R-type, LW, SW and BEQ; any other opcode traps, or is
//            dropped back to FETCH when TRAP_ON_ILLEGAL = 0. Memory states
//            stretch on mem_ready, and completed instructions are counted.
// Ports    : clk, rst_n (async, active-low)
//            opcode[6:0]  - IR[6:0], valid from DECODE until the next FETCH
//            mem_ready    - memory finishes the current access this cycle
//            halt_clr     - releases TRAP
//            pc_write, pc_write_cond, pc_source, ir_write, i_or_d,
//            mem_read, mem_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//            mem_to_reg, reg_write - datapath controls
//            state_o[3:0] - current state (debug)
//            trap         - high while in TRAP
//            instr_retired[RETIRE_W-1:0] - wrapping retired-instruction count
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int RETIRE_W        = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic                mem_ready,
  input  logic                halt_clr,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_source,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [3:0]          state_o,
  output logic                trap,
  output logic [RETIRE_W-1:0] instr_retired
);

  localparam logic [6:0] c_OP_R  = 7'b0110011;
  localparam logic [6:0] c_OP_LW = 7'b0000011;
  localparam logic [6:0] c_OP_SW = 7'b0100011;
  localparam logic [6:0] c_OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    TRAP      = 4'd9
  } state_t;

  state_t              r_state;
  logic [RETIRE_W-1:0] r_retired;
  logic                w_retire;

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      MEM_WB, R_WB, BRANCH: w_retire = 1'b1;
      MEM_WRITE:            w_retire = mem_ready;
      default:              w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
      case (r_state)
        FETCH: begin
          if (mem_ready) r_state <= DECODE;
        end
        DECODE: begin
          case (opcode)
            c_OP_LW, c_OP_SW: r_state <= MEM_ADDR;
            c_OP_R:           r_state <= EXECUTE;
            c_OP_BR:          r_state <= BRANCH;
            default:          r_state <= TRAP_ON_ILLEGAL ? TRAP : FETCH;
          endcase
        end
        // Only LW/SW reach MEM_ADDR, and opcode is held, so SW vs not-SW suffices.
        MEM_ADDR:  r_state <= (opcode == c_OP_SW) ? MEM_WRITE : MEM_READ;
        MEM_READ: begin
          if (mem_ready) r_state <= MEM_WB;
        end
        MEM_WB:    r_state <= FETCH;
        MEM_WRITE: begin
          if (mem_ready) r_state <= FETCH;
        end
        EXECUTE:   r_state <= R_WB;
        R_WB:      r_state <= FETCH;
        BRANCH:    r_state <= FETCH;
        TRAP: begin
          if (halt_clr) r_state <= FETCH;
        end
        default:   r_state <= FETCH;
      endcase
    end
  end

  // Moore decode; FETCH additionally gates the IR/PC loads with mem_ready so
  // they fire only on the cycle the instruction word actually arrives.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    trap          = 1'b0;
    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b10;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: begin
        trap = 1'b0;
      end
    endcase
  end

  assign state_o       = r_state;
  assign instr_retired = r_retired;

endmodule
`default_nettype wire
